spi_regbank_rw: RTL

Parametrised SPI mode-0 peripheral giving an external controller write and read access to a bank of NUM_REGS configuration registers of DATA_W bits each. It succeeds the fixed 5x8-bit write-only peripheral with four additions: configurable geometry, read-back on CIPO, per-register write strobes and a frame-error pulse. The block sits between the chip's SPI pins and the PWM/output-enable logic, which consumes the flat register vector.

---
 rtl/spi_regbank_pkg.sv | 13 +
 rtl/spi_regbank_rw_sync.sv | 32 +++
 rtl/spi_regbank_rw.sv | 125 ++++++++++++
 3 files changed

// File: rtl/spi_regbank_pkg.sv
// spi_regbank_pkg: shared FSM states, opcodes and frame geometry helper
package spi_regbank_pkg;

    typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, RDATA, DONE} state_t;

    localparam logic WRITE = 1'b1;
    localparam logic READ  = 1'b0;

    function automatic int frame_len(input int addr_w, input int data_w);
        return 1 + addr_w + data_w;
    endfunction

endpackage

// File: rtl/spi_regbank_rw_sync.sv
// spi_sync_edge: multi-flop synchroniser with registered edge strobes
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;

    assign q = sync[SYNC_STAGES-1];

    // shift the pin through the synchroniser and flag edges of its output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= {SYNC_STAGES{RESET_VAL}};
            prev <= RESET_VAL;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], d};
            prev <= q;
            rise <= q & ~prev;
            fall <= ~q & prev;
        end
    end
endmodule

// File: rtl/spi_regbank_rw.sv
// spi_regbank_rw: SPI mode-0 peripheral with read/write access to a register bank
module spi_regbank_rw
    import spi_regbank_pkg::*;
#(
    parameter int NUM_REGS    = 5,
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sclk,
    input  logic                       ncs,
    input  logic                       copi,
    output logic                       cipo,
    output logic                       cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0] regs_flat,
    output logic [NUM_REGS-1:0]        wr_pulse,
    output logic                       frame_err
);
    localparam int FL = frame_len(ADDR_W, DATA_W);
    localparam int CW = $clog2(FL + 1);
    localparam int SW = ADDR_W > DATA_W ? ADDR_W : DATA_W;

    state_t            state, state_n;
    logic              sclk_q, sclk_rise, sclk_fall;
    logic              ncs_q, ncs_rise, ncs_fall;
    logic              copi_q, copi_rise, copi_fall;
    logic              unused_ok;
    logic [CW-1:0]     cnt;
    logic [SW-1:0]     sh, sh_n;
    logic [DATA_W-1:0] sout, rd_data;
    logic [ADDR_W-1:0] addr;
    logic              rw, overrun, addr_ok, commit, last_addr, last_bit;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk (
        .clk(clk), .rst(rst), .d(sclk), .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall));
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ncs (
        .clk(clk), .rst(rst), .d(ncs), .q(ncs_q), .rise(ncs_rise), .fall(ncs_fall));
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_copi (
        .clk(clk), .rst(rst), .d(copi), .q(copi_q), .rise(copi_rise), .fall(copi_fall));

    assign unused_ok = ^{sclk_q, ncs_q, copi_rise, copi_fall};
    assign sh_n      = {sh[SW-2:0], copi_q};
    assign last_addr = cnt == CW'(ADDR_W);
    assign last_bit  = cnt == CW'(FL - 1);
    assign addr_ok   = {1'b0, addr} < (ADDR_W + 1)'(NUM_REGS);
    assign commit    = ncs_rise && state == DONE && !overrun && rw == WRITE && addr_ok;

    // read mux on the address being completed; unimplemented addresses read 0
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (sh_n[ADDR_W-1:0] == ADDR_W'(i)) rd_data = regs_flat[i*DATA_W +: DATA_W];
    end

    // frame state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // chip-select edges override everything; SCLK rises advance the frame
    always_comb begin
        state_n = state;
        if (ncs_rise) state_n = IDLE;
        else if (ncs_fall) state_n = CMD;
        else if (sclk_rise)
            case (state)
                CMD:          state_n = ADDR;
                ADDR:         if (last_addr) state_n = rw == WRITE ? WDATA : RDATA;
                WDATA, RDATA: if (last_bit) state_n = DONE;
                default:      ;
            endcase
    end

    // shift registers, bit counter, CIPO driver and commit into the register bank
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            sh        <= '0;
            sout      <= '0;
            addr      <= '0;
            rw        <= 1'b0;
            overrun   <= 1'b0;
            cipo      <= 1'b0;
            cipo_oe   <= 1'b0;
            regs_flat <= '0;
            wr_pulse  <= '0;
            frame_err <= 1'b0;
        end else begin
            wr_pulse  <= '0;
            frame_err <= 1'b0;
            if (state != RDATA) cipo <= 1'b0;
            if (ncs_fall) begin
                cnt     <= '0;
                sh      <= '0;
                overrun <= 1'b0;
                cipo_oe <= 1'b1;
            end else if (ncs_rise) begin
                cipo_oe <= 1'b0;
                if (state != IDLE) frame_err <= state != DONE || overrun || !addr_ok;
                for (int i = 0; i < NUM_REGS; i++)
                    if (commit && addr == ADDR_W'(i)) begin
                        regs_flat[i*DATA_W +: DATA_W] <= sh[DATA_W-1:0];
                        wr_pulse[i]                   <= 1'b1;
                    end
            end else if (sclk_rise && state != IDLE) begin
                if (state == DONE) overrun <= 1'b1;
                else begin
                    cnt <= cnt + 1'b1;
                    sh  <= sh_n;
                end
                if (state == CMD) rw <= copi_q;
                if (state == ADDR && last_addr) begin
                    addr <= sh_n[ADDR_W-1:0];
                    sout <= rd_data;
                end
            end else if (sclk_fall && state == RDATA) begin
                cipo <= sout[DATA_W-1];
                sout <= {sout[DATA_W-2:0], 1'b0};
            end
        end
    end
endmodule
